// File: rtl/online_div_seq.sv
// online_div_seq: radix-2 online divider, MSD-first signed-digit in/out, with on-the-fly quotient conversion.
// Ports: clk/asyn_reset (async active-low); enable_all freezes everything;
//   start/busy/done frame the operation; in_valid/in_ready pace x_value/d_value digit pairs;
//   q_value/q_valid stream quotient digits; q_conv holds the two's-complement quotient at frame end.
module online_div_seq #(
  parameter int PRECISION = 64,
  parameter int ONLINE_DELAY = 4,
  parameter int CNT_WIDTH = 11
) (
  input  logic clk,
  input  logic asyn_reset,
  input  logic enable_all,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic [1:0] x_value,
  input  logic [1:0] d_value,
  output logic [1:0] q_value,
  output logic q_valid,
  output logic busy,
  output logic done,
  output logic [PRECISION:0] q_conv
);
  localparam int WW = PRECISION + ONLINE_DELAY + 3;
  localparam int DW = PRECISION + 2;
  localparam int QW = PRECISION + 1;
  localparam logic [CNT_WIDTH-1:0] K_IN = CNT_WIDTH'(PRECISION);
  localparam logic [CNT_WIDTH-1:0] K_DLY = CNT_WIDTH'(ONLINE_DELAY);
  localparam logic [CNT_WIDTH-1:0] K_LAST = CNT_WIDTH'(PRECISION + ONLINE_DELAY - 1);
  localparam logic signed [WW-1:0] QUARTER = WW'(1) << (PRECISION + ONLINE_DELAY - 2);
  localparam logic signed [WW-1:0] X_ONE = WW'(1) << PRECISION;
  localparam logic [DW-1:0] D_MSB = DW'(1) << (PRECISION - 1);
  localparam logic [QW-1:0] Q_MSB = QW'(1) << (PRECISION - 1);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] k_q, k_d;
  logic signed [WW-1:0] w_q, w_d;
  logic signed [DW-1:0] dreg_q, dreg_d;
  logic [QW-1:0] qp_q, qp_d, qm_q, qm_d, conv_q, conv_d;
  logic [1:0] qv_q, qv_d;
  logic qvld_q, qvld_d, done_q, done_d;
  logic in_phase, fire, sel, q_pos, q_neg;
  logic [1:0] x_eff, d_eff;
  logic signed [WW-1:0] x_term, qd_term, v, d_shift, q_ext, d_ext;
  logic signed [DW-1:0] d_step, dreg_nx;
  logic [QW-1:0] ins_bit, keep_hi;
  logic [CNT_WIDTH-1:0] j_idx;
  assign busy = state_q == S_RUN;
  assign in_ready = busy && enable_all && in_phase;
  assign q_valid = qvld_q && enable_all;
  assign done = done_q && enable_all;
  assign q_value = qv_q;
  assign q_conv = conv_q;
  // W is scaled by 2^(PRECISION+ONLINE_DELAY), Dreg and Q by 2^PRECISION.
  always_comb begin
    in_phase = k_q < K_IN;
    fire = busy && enable_all && (!in_phase || in_valid);
    x_eff = in_phase ? x_value : 2'b00;
    d_eff = in_phase ? d_value : 2'b00;
    d_step = $signed(D_MSB >> k_q);
    dreg_nx = d_eff == 2'b10 ? dreg_q + d_step : d_eff == 2'b01 ? dreg_q - d_step : dreg_q;
    q_ext = {{(WW-QW){qp_q[QW-1]}}, qp_q};
    x_term = x_eff == 2'b10 ? X_ONE : x_eff == 2'b01 ? -X_ONE : '0;
    qd_term = d_eff == 2'b10 ? q_ext : d_eff == 2'b01 ? -q_ext : '0;
    v = (w_q <<< 1) + x_term - qd_term;
    sel = k_q >= K_DLY;
    q_pos = sel && (v >= QUARTER);
    q_neg = sel && (v < -QUARTER);
    d_ext = {{(WW-DW){dreg_nx[DW-1]}}, dreg_nx};
    d_shift = d_ext <<< ONLINE_DELAY;
    // Bit insertion at weight 2^-j: keep the digits above it, set or clear it, zero below.
    // QM starts as all ones so its kept sign bits read as -1 for the first digit.
    j_idx = k_q - K_DLY;
    ins_bit = Q_MSB >> j_idx;
    keep_hi = ~((ins_bit << 1) - QW'(1));
    state_d = state_q;
    k_d = k_q;
    w_d = w_q;
    dreg_d = dreg_q;
    qp_d = qp_q;
    qm_d = qm_q;
    conv_d = conv_q;
    qv_d = qv_q;
    qvld_d = qvld_q;
    done_d = done_q;
    if (enable_all) begin
      qv_d = 2'b00;
      qvld_d = 1'b0;
      done_d = 1'b0;
      if (!busy && start) begin
        state_d = S_RUN;
        k_d = '0;
        w_d = '0;
        dreg_d = '0;
        qp_d = '0;
        qm_d = '1;
        conv_d = '0;
      end else if (fire) begin
        k_d = k_q + 1'b1;
        w_d = q_pos ? v - d_shift : q_neg ? v + d_shift : v;
        dreg_d = dreg_nx;
        qp_d = q_pos ? (qp_q & keep_hi) | ins_bit : q_neg ? (qm_q & keep_hi) | ins_bit : qp_q;
        qm_d = !sel ? qm_q : q_pos ? qp_q & keep_hi : q_neg ? qm_q & keep_hi : (qm_q & keep_hi) | ins_bit;
        qv_d = q_pos ? 2'b10 : q_neg ? 2'b01 : 2'b00;
        qvld_d = sel;
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
          done_d = 1'b1;
          conv_d = qp_d;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state_q <= S_IDLE;
      k_q <= '0;
      w_q <= '0;
      dreg_q <= '0;
      qp_q <= '0;
      qm_q <= '0;
      conv_q <= '0;
      qv_q <= 2'b00;
      qvld_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      w_q <= w_d;
      dreg_q <= dreg_d;
      qp_q <= qp_d;
      qm_q <= qm_d;
      conv_q <= conv_d;
      qv_q <= qv_d;
      qvld_q <= qvld_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_online_div_seq.sv
// tb_online_div_seq: table, corner-case and randomized checks of online_div_seq against an arithmetic model.
module tb_online_div_seq;
  localparam int P = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic asyn_reset, enable_all, start, in_valid, in_ready, q_valid, busy, done;
  logic [1:0] x_value, d_value, q_value;
  logic [P:0] q_conv;
  int n_cmp = 0;
  int n_bad = 0;
  online_div_seq #(.PRECISION(P), .ONLINE_DELAY(D), .CNT_WIDTH(11)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .enable_all(enable_all), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .x_value(x_value), .d_value(d_value),
    .q_value(q_value), .q_valid(q_valid), .busy(busy), .done(done), .q_conv(q_conv)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] x;
    logic [15:0] d;
    logic [15:0] qd;
    logic [8:0] conv;
  } vec_t;
  vec_t tbl[4];
  int mdig[P];
  logic [15:0] got_q;
  int got_n, first_n, done_n;
  logic [8:0] got_conv;
  bit got_done;
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask
  function automatic int dg(input logic [1:0] e);
    return e == 2'b10 ? 1 : e == 2'b01 ? -1 : 0;
  endfunction
  function automatic int digit_at(input logic [15:0] s, input int i);
    logic [15:0] t;
    t = s << (2 * i);
    return dg(t[15:14]);
  endfunction
  // Recurrence in plain integers: W, Dreg and Q all scaled by 2^(P+D) = 4096.
  function automatic logic [8:0] model(input logic [15:0] xv, input logic [15:0] dv);
    longint w, dr, q, v;
    int xk, dk, qj;
    w = 0;
    dr = 0;
    q = 0;
    for (int k = 1; k <= P + D; k++) begin
      xk = k <= P ? digit_at(xv, k - 1) : 0;
      dk = k <= P ? digit_at(dv, k - 1) : 0;
      dr += dk * (4096 >> k);
      v = 2 * w + xk * 256 - q * dk / 16;
      qj = 0;
      if (k > D) qj = v >= 1024 ? 1 : v < -1024 ? -1 : 0;
      w = v - qj * dr;
      if (k > D) begin
        mdig[k - D - 1] = qj;
        q += qj * (4096 >> (k - D));
      end
    end
    return 9'(q / 16);
  endfunction
  function automatic logic [15:0] model_digits();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < P; i++) r = {r[13:0], mdig[i] == 1 ? 2'b10 : mdig[i] == -1 ? 2'b01 : 2'b00};
    return r;
  endfunction
  function automatic int value8(input logic [15:0] s);
    int r;
    r = 0;
    for (int i = 0; i < P; i++) r += digit_at(s, i) * (256 >> (i + 1));
    return r;
  endfunction
  task automatic run_frame(input logic [15:0] xv, input logic [15:0] dv, input int st_a, input int st_b,
                           input bit rnd, input int restart_n);
    int idx, n, stall;
    bit sa, sb;
    logic [15:0] tx, td;
    idx = 0;
    n = 1;
    stall = 0;
    sa = 0;
    sb = 0;
    got_q = '0;
    got_n = 0;
    first_n = -1;
    done_n = -1;
    got_done = 0;
    got_conv = '0;
    start = 1'b1;
    in_valid = 1'b0;
    enable_all = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_clears_conv", q_conv, 0);
    while (!got_done && n < 400) begin
      if (!enable_all) check("frozen_outputs", {q_valid, done, in_ready}, 0);
      if (q_valid) begin
        got_q = {got_q[13:0], q_value};
        got_n++;
        if (first_n < 0) first_n = n;
      end
      if (done) begin
        got_done = 1;
        done_n = n;
        got_conv = q_conv;
        check("done_with_valid", q_valid, 1);
        check("idle_after_done", busy, 0);
      end else begin
        enable_all = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (idx + 1 == st_a && !sa) begin sa = 1; stall = 3; end
        if (idx + 1 == st_b && !sb) begin sb = 1; stall = 3; end
        in_valid = idx < P && stall == 0 && (!rnd || $urandom_range(0, 2) != 0);
        if (stall > 0) stall--;
        tx = xv << (2 * idx);
        td = dv << (2 * idx);
        x_value = idx < P ? tx[15:14] : 2'($urandom);
        d_value = idx < P ? td[15:14] : 2'($urandom);
        start = n == restart_n;
        #2;
        if (in_valid && in_ready) idx++;
        @(posedge clk);
        #1;
        n++;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    enable_all = 1'b1;
    if (!got_done) check("frame_timeout", 0, 1);
  endtask
  initial begin
    logic [15:0] rx, rd;
    logic [8:0] exp_conv;
    int ndone, tries;
    asyn_reset = 1'b0;
    enable_all = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    x_value = 2'b00;
    d_value = 2'b00;
    #12;
    check("reset_outputs", {busy, q_valid, done, in_ready, q_value, q_conv}, 0);
    @(negedge clk);
    asyn_reset = 1'b1;
    @(posedge clk);
    #1;
    enable_all = 1'b1;
    tbl[0] = '{16'h2000, 16'h8000, 16'h8000, 9'h080};
    tbl[1] = '{16'h1000, 16'h8000, 16'h4000, 9'h180};
    tbl[2] = '{16'h0000, 16'hA000, 16'h0000, 9'h000};
    tbl[3] = '{16'h2000, 16'hA000, 16'h9999, 9'h055};
    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].x, tbl[i].d, 0, 0, 0, -1);
      exp_conv = model(tbl[i].x, tbl[i].d);
      check("tbl_digits", got_q, tbl[i].qd);
      check("tbl_conv", got_conv, tbl[i].conv);
      check("tbl_model_digits", got_q, model_digits());
      check("tbl_model_conv", got_conv, exp_conv);
      check("tbl_valid_count", got_n, P);
      check("tbl_first_valid", first_n, 6);
      check("tbl_done_cycle", done_n, 13);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("idle_conv_hold", q_conv, 9'h055);
    check("idle_quiet", {busy, q_valid, done}, 0);
    run_frame(16'h2000, 16'h8000, 2, 7, 0, -1);
    check("stall_first_valid", first_n, 9);
    check("stall_done_cycle", done_n, 19);
    check("stall_conv", got_conv, 9'h080);
    check("stall_digits", got_q, 16'h8000);
    check("stall_valid_count", got_n, P);
    run_frame(16'h2000, 16'h8000, 0, 0, 0, 4);
    check("restart_ignored_done", done_n, 13);
    check("restart_ignored_conv", got_conv, 9'h080);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x_value = digit_at(16'h2000, i) == 1 ? 2'b10 : 2'b00;
      d_value = digit_at(16'h8000, i) == 1 ? 2'b10 : 2'b00;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    check("pre_reset_valid", {q_valid, q_value}, 3'b110);
    #2;
    asyn_reset = 1'b0;
    #1;
    check("midframe_reset_outputs", {busy, q_valid, done, in_ready, q_value, q_conv}, 0);
    @(negedge clk);
    asyn_reset = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("no_done_after_abort", ndone, 0);
    check("idle_after_abort", busy, 0);
    in_valid = 1'b0;
    run_frame(16'h2000, 16'h8000, 0, 0, 0, -1);
    check("post_abort_conv", got_conv, 9'h080);
    check("post_abort_done", done_n, 13);
    for (int f = 0; f < 30; f++) begin
      tries = 0;
      do begin
        rx = 16'($urandom) & 16'h0FFF | (16'($urandom) & 16'h3000);
        rx[15:14] = 2'b00;
        rd = 16'($urandom);
        rd[15:14] = 2'b10;
        tries++;
      end while (tries < 100 && !(value8(rd) >= 128 && 2 * (value8(rx) < 0 ? -value8(rx) : value8(rx)) < value8(rd)));
      if (tries >= 100) begin
        rx = 16'h2000;
        rd = 16'hA000;
      end
      exp_conv = model(rx, rd);
      run_frame(rx, rd, 0, 0, 1, -1);
      check("rnd_digits", got_q, model_digits());
      check("rnd_conv", got_conv, exp_conv);
      check("rnd_valid_count", got_n, P);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/online_div_seq.md
Name: online_div_seq

Overview:
- Parametrised radix-2 online divider for the Newton datapath.
- Consumes dividend and divisor as MSD-first signed-digit streams and emits quotient digits MSD-first after ONLINE_DELAY.
- Successor to the fixed 64-digit divider. New in this generation:
  - precision and online delay are parameters;
  - frames are delimited by a start/done handshake, with input stall support;
  - the block runs its own flush tail after the last input digit;
  - a two's-complement quotient is available at frame end via on-the-fly conversion.

Parameters:
PRECISION, 64, number of input digits per operand and number of quotient digits per frame
ONLINE_DELAY, 4, online delay δ; number of iterations before the first quotient digit (minimum 2)
CNT_WIDTH, 11, iteration counter width; must satisfy 2^CNT_WIDTH > PRECISION+ONLINE_DELAY

Ports:
clk  input  1  rising-edge clock
asyn_reset  input  1  asynchronous active-low reset
enable_all  input  1  global enable; when low, all state is frozen and outputs hold
start  input  1  single-cycle frame start pulse, accepted only when busy=0
in_valid  input  1  x_value/d_value hold a valid digit pair
in_ready  output  1  block accepts a digit pair this cycle
x_value  input  2  dividend digit: 2'b10=+1, 2'b01=-1, 2'b00 or 2'b11 = 0
d_value  input  2  divisor digit, same encoding
q_value  output  2  quotient digit, same encoding (2'b11 never driven)
q_valid  output  1  q_value valid this cycle
busy  output  1  frame in progress
done  output  1  one-cycle pulse coinciding with the final q_valid
q_conv  output  PRECISION+1  two's-complement quotient; value = q_conv·2^-PRECISION

Behaviour:
- Reset (asyn_reset=0): all state clears immediately; every output is 0, including q_conv and q_value=2'b00.
- Idle: start=1 and enable_all=1 → busy=1 next cycle. Clears k=0, W=0, Dreg=0, Q=0, QM=-2^-PRECISION. q_conv is cleared. start while busy is ignored.
- Iteration counter k runs 1..PRECISION+δ. One iteration executes per enabled cycle when:
  - k ≤ PRECISION and in_valid=1 (digit pair k consumed), or
  - k > PRECISION (flush: x and d digits taken as 0, no in_valid needed).
- in_ready = busy & enable_all & (k ≤ PRECISION). If in_valid=0 while k ≤ PRECISION, the iteration stalls and no state changes.
- Arithmetic: W is exact two's complement with 3 integer bits (sign included) and PRECISION+δ fraction bits. No truncation. Per iteration with input digits x_k, d_k (j = k−δ):
  - Dreg ← Dreg + d_k·2^-k (conventional divisor, PRECISION fraction bits).
  - v = 2W + x_k·2^-δ − Q·d_k·2^-δ.
  - If j ≤ 0: q=0, W ← v.
  - If j ≥ 1: q_j = +1 if v ≥ 1/4; −1 if v < −1/4; else 0. W ← v − q_j·Dreg (Dreg already updated).
- On-the-fly conversion for j ≥ 1, with ulp = 2^-j:
  - q=+1: Q ← Q+ulp, QM ← Q.
  - q=0: QM ← Q−ulp.
  - q=−1: Q ← QM+ulp, QM ← QM.
  - Implemented by bit insertion, not addition.
- Output latency: q_j is registered. q_value/q_valid are asserted in the cycle after the iteration that produced it. The first q_valid follows iteration δ+1.
- Frame end: iteration k=PRECISION+δ produces q_PRECISION. Next cycle: q_valid=1, done=1, q_conv=Q, busy=0. q_conv holds until the next accepted start or reset.
- start is accepted in the same cycle done is high.
- enable_all=0 freezes counters, W, Q, in_ready=0. q_valid and done are forced to 0 while frozen and resume after.
- Precondition: Dreg ≥ 1/2 and |X| < Dreg/2. Outside it, digits and q_conv are unspecified, but the frame must still complete in exactly PRECISION+δ iterations and assert done.
- Reset mid-frame aborts immediately. No done is produced. The next start begins a clean frame.

Test Plan:
- PRECISION=8, δ=4. x=0.01000000, d=0.10000000, in_valid held high → first q_valid 6 cycles after start acceptance (δ+1 iterations + 1 register). Exactly 8 q_valid. done on the 8th. q_conv=9'h080.
- x=0.0(−1)000000, d=0.10000000 → q_conv=9'h180 (−1/2). Digit stream sums to −1/2.
- x=0, d=0.11000000 → all q_value=2'b00, q_conv=9'h000.
- x=0.01000000, d=0.11000000 → digits and q_conv bit-exact to the recurrence model. |q_conv·2^-8 − 1/3| < 2^-8.
- Repeat the first case with in_valid low for 3 cycles at k=2 and k=7 → q_valid sequence shifts by 6 cycles total, same q_conv. Flush iterations 9..12 run with in_valid=0.
- Start pulse while busy → ignored. asyn_reset low at k=5 → all outputs 0 immediately, no done. A new frame afterwards yields q_conv=9'h080 for the first-case operands.
